// File: rtl/wb_ram_bist_master.sv
// Wishbone BIST master for the RAM bank: writes an address-derived pattern,
// reads it back, counts mismatches and records the first failing location.
module wb_ram_bist_master #(
  parameter logic [31:0] SEED    = 32'hFAB0_5A5A,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        start_i,
  input  logic [4:0]  ram_mask_i,
  output logic [10:0] WBs_ADR_o,
  output logic        WBs_RAM0_CYC_o,
  output logic        WBs_RAM1_CYC_o,
  output logic        WBs_RAM2_CYC_o,
  output logic        WBs_RAM3_CYC_o,
  output logic        WBs_RAM4_CYC_o,
  output logic [3:0]  WBs_BYTE_STB_o,
  output logic        WBs_WE_o,
  output logic        WBs_STB_o,
  output logic [31:0] WBs_DAT_o,
  input  logic [31:0] WBs_RAM0_DAT_i,
  input  logic [31:0] WBs_RAM1_DAT_i,
  input  logic [31:0] WBs_RAM2_DAT_i,
  input  logic [31:0] WBs_RAM3_DAT_i,
  input  logic [31:0] WBs_RAM4_DAT_i,
  input  logic        WBs_ACK_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_cnt_o,
  output logic [2:0]  first_err_ram_o,
  output logic [10:0] first_err_adr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_RD,
    S_ABORT,
    S_DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t state, state_nx;

  logic [10:0] adr_q;
  logic [2:0]  ram_q;
  logic [4:0]  mask_q;
  logic        gap_rd_q;
  logic [7:0]  to_cnt_q;
  logic [15:0] err_q;
  logic        fe_vld_q;
  logic [2:0]  fe_ram_q;
  logic [10:0] fe_adr_q;
  logic        to_q;

  logic        start_ok;
  logic        active;
  logic        ack;
  logic        at_last;
  logic        to_hit;
  logic        mismatch;
  logic        has_next;
  logic [2:0]  nxt_ram;
  logic [4:0]  above;
  logic [10:0] last_adr;
  logic [31:0] pat;
  logic [31:0] wmask;
  logic [31:0] rd_dat;
  logic [15:0] err_inc;
  logic [4:0]  cyc_vec;

  function automatic logic [2:0] low_idx(input logic [4:0] m);
    low_idx = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (m[i]) low_idx = 3'(i);
  endfunction

  assign start_ok = start_i &
                    ((state == S_IDLE) | (state == S_DONE));
  assign active   = (state == S_WR) | (state == S_RD);
  assign ack      = active & WBs_ACK_i;
  assign at_last  = (adr_q == last_adr);
  assign to_hit   = active & ~WBs_ACK_i &
                    (to_cnt_q == TO_LAST);

  // Enabled RAMs strictly above the one under test
  assign above    = mask_q & ~((5'd2 << ram_q) - 5'd1);
  assign has_next = |above;
  assign nxt_ram  = low_idx(above);

  assign pat      = SEED ^ {ram_q, ~adr_q, 7'b0, adr_q};
  assign mismatch = (rd_dat != (pat & wmask));
  assign err_inc  = (err_q == 16'hFFFF) ? err_q
                                        : err_q + 16'd1;

  always_comb begin
    last_adr = 11'd2047;
    wmask    = 32'h0000_00FF;
    rd_dat   = WBs_RAM4_DAT_i;
    unique case (ram_q)
      3'd0: begin
        last_adr = 11'd511;
        wmask    = 32'h0000_FFFF;
        rd_dat   = WBs_RAM0_DAT_i;
      end
      3'd1: begin
        last_adr = 11'd1023;
        wmask    = 32'h0000_FFFF;
        rd_dat   = WBs_RAM1_DAT_i;
      end
      3'd2: begin
        last_adr = 11'd1023;
        wmask    = 32'h0000_00FF;
        rd_dat   = WBs_RAM2_DAT_i;
      end
      3'd3: begin
        last_adr = 11'd511;
        wmask    = 32'hFFFF_FFFF;
        rd_dat   = WBs_RAM3_DAT_i;
      end
      default: begin
        last_adr = 11'd2047;
        wmask    = 32'h0000_00FF;
        rd_dat   = WBs_RAM4_DAT_i;
      end
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start_i)
          state_nx = (ram_mask_i == 5'd0) ? S_DONE : S_WR;
      end
      S_WR: begin
        if (to_hit)                 state_nx = S_ABORT;
        else if (ack && at_last)    state_nx = S_GAP;
      end
      S_GAP: begin
        state_nx = gap_rd_q ? S_RD : S_WR;
      end
      S_RD: begin
        if (to_hit)
          state_nx = S_ABORT;
        else if (ack && at_last)
          state_nx = has_next ? S_GAP : S_DONE;
      end
      S_ABORT: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_vec   = 5'd0;
    WBs_STB_o = 1'b0;
    WBs_WE_o  = 1'b0;
    WBs_ADR_o = 11'd0;
    WBs_DAT_o = 32'd0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state)
      S_WR: begin
        cyc_vec   = 5'd1 << ram_q;
        WBs_STB_o = 1'b1;
        WBs_WE_o  = 1'b1;
        WBs_ADR_o = adr_q;
        WBs_DAT_o = pat;
        busy_o    = 1'b1;
      end
      S_RD: begin
        cyc_vec   = 5'd1 << ram_q;
        WBs_STB_o = 1'b1;
        WBs_ADR_o = adr_q;
        busy_o    = 1'b1;
      end
      S_GAP, S_ABORT: busy_o = 1'b1;
      S_DONE:         done_o = 1'b1;
      default: ;
    endcase
  end

  assign WBs_RAM0_CYC_o  = cyc_vec[0];
  assign WBs_RAM1_CYC_o  = cyc_vec[1];
  assign WBs_RAM2_CYC_o  = cyc_vec[2];
  assign WBs_RAM3_CYC_o  = cyc_vec[3];
  assign WBs_RAM4_CYC_o  = cyc_vec[4];
  assign WBs_BYTE_STB_o  = 4'hF;
  assign pass_o          = done_o & (err_q == 16'd0) & ~to_q;
  assign timeout_o       = to_q;
  assign err_cnt_o       = err_q;
  assign first_err_ram_o = fe_ram_q;
  assign first_err_adr_o = fe_adr_q;

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      adr_q    <= '0;
      ram_q    <= '0;
      mask_q   <= '0;
      gap_rd_q <= 1'b0;
      to_cnt_q <= '0;
      err_q    <= '0;
      fe_vld_q <= 1'b0;
      fe_ram_q <= '0;
      fe_adr_q <= '0;
      to_q     <= 1'b0;
    end else if (start_ok) begin
      mask_q   <= ram_mask_i;
      ram_q    <= low_idx(ram_mask_i);
      adr_q    <= '0;
      gap_rd_q <= 1'b0;
      to_cnt_q <= '0;
      err_q    <= '0;
      fe_vld_q <= 1'b0;
      fe_ram_q <= '0;
      fe_adr_q <= '0;
      to_q     <= 1'b0;
    end else if (ack) begin
      to_cnt_q <= '0;
      if (at_last) begin
        adr_q <= '0;
        if (state == S_WR) begin
          gap_rd_q <= 1'b1;
        end else begin
          gap_rd_q <= 1'b0;
          ram_q    <= nxt_ram;
        end
      end else begin
        adr_q <= adr_q + 11'd1;
      end
      if ((state == S_RD) && mismatch) begin
        err_q <= err_inc;
        if (!fe_vld_q) begin
          fe_vld_q <= 1'b1;
          fe_ram_q <= ram_q;
          fe_adr_q <= adr_q;
        end
      end
    end else if (to_hit) begin
      // The abort itself is recorded as an error
      to_q     <= 1'b1;
      to_cnt_q <= '0;
      err_q    <= err_inc;
      if (!fe_vld_q) begin
        fe_vld_q <= 1'b1;
        fe_ram_q <= ram_q;
        fe_adr_q <= adr_q;
      end
    end else if (active) begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

endmodule
